// File: rtl/muldiv_unit_pkg.sv
// Shared types and encodings for the RV32M multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;
    localparam logic [6:0] OPCODE_OP    = 7'b0110011;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit with valid/ready handshakes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic [2:0]      func3_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned    CNT_W   = $clog2(XLEN) + 1;
    localparam int unsigned    AW      = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e    state_q, state_d;
    muldiv_op_e       op_q, op_d, op_in;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d, special_q, special_d;
    logic             valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic             a_neg_in, b_neg_in, div0_in, ovf_in;
    logic [XLEN-1:0]  a_mag_in, b_mag_in;
    logic [XLEN:0]    mul_upper, div_shift, div_diff;
    logic [AW-1:0]    mul_next, div_next, prod_s;
    logic [XLEN-1:0]  quo, rem, res_c;

    // Request decode: operand magnitudes, sign flags and early-out detection
    always_comb begin
        op_in    = muldiv_op_e'(func3_i);
        a_neg_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && data1_i[XLEN-1];
        b_neg_in = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && data2_i[XLEN-1];
        a_mag_in = a_neg_in ? -data1_i : data1_i;
        b_mag_in = b_neg_in ? -data2_i : data2_i;
        div0_in  = func3_i[2] && (data2_i == '0);
        ovf_in   = (op_in inside {OP_DIV, OP_REM}) && (data1_i == MIN_INT) && (data2_i == '1);
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_upper = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next  = {mul_upper, acc_q[XLEN-1:1]};
        div_shift = acc_q[AW-1:XLEN-1];
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Final result: apply stored signs unless the op was an early-out
    always_comb begin
        prod_s = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quo    = acc_q[XLEN-1:0];
        rem    = acc_q[AW-1:XLEN];
        if (!special_q) begin
            if (a_neg_q ^ b_neg_q) quo = -acc_q[XLEN-1:0];
            if (a_neg_q)           rem = -acc_q[AW-1:XLEN];
        end
        unique case (op_q)
            OP_MUL:                        res_c = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res_c = prod_s[AW-1:XLEN];
            OP_DIV, OP_DIVU:               res_c = quo;
            default:                       res_c = rem;
        endcase
    end

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        special_d = special_q;
        valid_d   = valid_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (valid_i && ready_q && !flush_i) begin
                    op_d      = op_in;
                    a_neg_d   = a_neg_in;
                    b_neg_d   = b_neg_in;
                    b_d       = b_mag_in;
                    special_d = div0_in || ovf_in;
                    cnt_d     = CNT_W'(XLEN);
                    if (div0_in) begin
                        acc_d   = {data1_i, {XLEN{1'b1}}};
                        state_d = DONE;
                    end else if (ovf_in) begin
                        acc_d   = {{XLEN{1'b0}}, data1_i};
                        state_d = DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, a_mag_in};
                        state_d = func3_i[2] ? DIV : MUL;
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            default: begin
                if (!valid_q) begin
                    valid_d  = 1'b1;
                    result_d = res_c;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase

        if (flush_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            special_q <= special_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign valid_o  = valid_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed 32-bit vectors, handshake corner cases, 16-bit random sweep.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v32_i, r32_o, fl32, v32_o, rdy32_i, busy32;
    logic [2:0]  f32;
    logic [31:0] a32, b32, res32;
    logic        v16_i, r16_o, fl16, v16_o, rdy16_i, busy16;
    logic [2:0]  f16;
    logic [15:0] a16, b16, res16;

    int checks = 0;
    int errors = 0;

    logic [31:0] q32[$];
    logic [15:0] q16[$];

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v32_i), .ready_o(r32_o),
        .data1_i(a32), .data2_i(b32), .func3_i(f32), .flush_i(fl32),
        .valid_o(v32_o), .ready_i(rdy32_i), .result_o(res32), .busy_o(busy32)
    );

    muldiv_unit #(.XLEN(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v16_i), .ready_o(r16_o),
        .data1_i(a16), .data2_i(b16), .func3_i(f16), .flush_i(fl16),
        .valid_o(v16_o), .ready_i(rdy16_i), .result_o(res16), .busy_o(busy16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // valid_o and ready_o must never be high together
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((v32_o && r32_o) || (v16_o && r16_o)) begin
                errors++;
                $display("FAIL valid_ready_overlap: got 1 expected 0 at %0t", $time);
            end
        end
    end

    task automatic start32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        @(negedge clk);
        chk("ready_before_issue", r32_o, 1);
        v32_i = 1'b1; f32 = f; a32 = a; b32 = b;
        @(posedge clk);
        #1;
        v32_i = 1'b0; a32 = $urandom(); b32 = $urandom();
        q32.push_back(exp);
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (!v32_o && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic collect32(input string name, input int exp_lat);
        int lat;
        logic [31:0] exp;
        wait32(lat);
        exp = q32.pop_front();
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, res32, exp);
        @(posedge clk);
        #1;
        chk({name, "_idle_after_handshake"}, {v32_o, r32_o}, 2'b01);
    endtask

    function automatic void ref16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output int lat);
        longint sa, sb, ua, ub, p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 16'h8000) && (b == 16'hffff);
        lat = 17;
        p   = 0;
        case (f)
            3'b000: begin p = sa * sb; r = p[15:0];  end
            3'b001: begin p = sa * sb; r = p[31:16]; end
            3'b010: begin p = sa * ub; r = p[31:16]; end
            3'b011: begin p = ua * ub; r = p[31:16]; end
            3'b100: begin
                if (b == 0)   begin r = 16'hffff; lat = 1; end
                else if (ovf) begin r = 16'h8000; lat = 1; end
                else          r = 16'(sa / sb);
            end
            3'b101: begin
                if (b == 0) begin r = 16'hffff; lat = 1; end
                else        r = 16'(ua / ub);
            end
            3'b110: begin
                if (b == 0)   begin r = a; lat = 1; end
                else if (ovf) begin r = 16'h0000; lat = 1; end
                else          r = 16'(sa % sb);
            end
            default: begin
                if (b == 0) begin r = a; lat = 1; end
                else        r = 16'(ua % ub);
            end
        endcase
    endfunction

    task automatic run16(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        int lat, elat;
        logic [15:0] exp;
        ref16(f, a, b, exp, elat);
        @(negedge clk);
        v16_i = 1'b1; f16 = f; a16 = a; b16 = b;
        @(posedge clk);
        #1;
        v16_i = 1'b0; a16 = 16'($urandom()); b16 = 16'($urandom());
        q16.push_back(exp);
        lat = 0;
        while (!v16_o && lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
        end
        exp = q16.pop_front();
        chk($sformatf("x16_f%0d_%h_%h_latency", f, a, b), 64'(lat), 64'(elat));
        chk($sformatf("x16_f%0d_%h_%h_result", f, a, b), res16, exp);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hffff;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int lat;
        logic seen;

        tbl[0]  = '{3'b000, 32'd6,        32'd5,        32'd30,       33};
        tbl[1]  = '{3'b001, 32'hffffffff, 32'hffffffff, 32'h00000000, 33};
        tbl[2]  = '{3'b011, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 33};
        tbl[3]  = '{3'b100, 32'hfffffff9, 32'd2,        32'hfffffffd, 33};
        tbl[4]  = '{3'b110, 32'hfffffff9, 32'd2,        32'hffffffff, 33};
        tbl[5]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
        tbl[6]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
        tbl[7]  = '{3'b100, 32'd5,        32'd0,        32'hffffffff, 1};
        tbl[8]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
        tbl[9]  = '{3'b101, 32'hfffffff9, 32'd0,        32'hffffffff, 1};
        tbl[10] = '{3'b111, 32'hfffffff9, 32'd0,        32'hfffffff9, 1};
        tbl[11] = '{3'b100, 32'h80000000, 32'hffffffff, 32'h80000000, 1};
        tbl[12] = '{3'b110, 32'h80000000, 32'hffffffff, 32'h00000000, 1};
        tbl[13] = '{3'b101, 32'h80000000, 32'hffffffff, 32'h00000000, 33};
        tbl[14] = '{3'b111, 32'h80000000, 32'hffffffff, 32'h80000000, 33};
        tbl[15] = '{3'b010, 32'hfffffffe, 32'd3,        32'hffffffff, 33};
        tbl[16] = '{3'b000, 32'hffffffff, 32'hffffffff, 32'h00000001, 33};
        tbl[17] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};

        rst_n = 1'b0;
        v32_i = 1'b0; fl32 = 1'b0; rdy32_i = 1'b1; f32 = 3'b000; a32 = '0; b32 = '0;
        v16_i = 1'b0; fl16 = 1'b0; rdy16_i = 1'b1; f16 = 3'b000; a16 = '0; b16 = '0;
        #12;
        chk("reset_outputs", {v32_o, busy32, res32}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", {r32_o, busy32, v32_o}, 3'b100);

        // directed vectors
        for (int i = 0; i < 18; i++) begin
            start32(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].r);
            collect32($sformatf("vec%0d", i), tbl[i].lat);
        end

        // backpressure: result held 10 cycles, then immediate back-to-back accept
        rdy32_i = 1'b0;
        start32(3'b101, 32'd100, 32'd7, 32'd14);
        wait32(lat);
        chk("bp_latency", 64'(lat), 64'd33);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_hold%0d", i), {v32_o, r32_o, busy32, res32}, {3'b101, 32'd14});
            @(posedge clk);
            #1;
        end
        void'(q32.pop_front());
        rdy32_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {v32_o, r32_o, busy32}, 3'b010);
        start32(3'b000, 32'd7, 32'd9, 32'd63);
        collect32("bp_back_to_back", 33);

        // flush at iteration 12 of a divide
        start32(3'b100, 32'd1000, 32'd3, 32'd333);
        void'(q32.pop_front());
        repeat (11) @(posedge clk);
        #1;
        fl32 = 1'b1;
        @(posedge clk);
        #1;
        fl32 = 1'b0;
        chk("flush_div_idle", {v32_o, r32_o, busy32}, 3'b010);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (v32_o) seen = 1'b1;
        end
        chk("flush_div_no_valid", seen, 0);
        start32(3'b010, 32'hfffffffe, 32'd3, 32'hffffffff);
        collect32("mulhsu_after_flush", 33);

        // flush wins over a request in IDLE
        @(negedge clk);
        v32_i = 1'b1; fl32 = 1'b1; f32 = 3'b000; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk);
        #1;
        v32_i = 1'b0; fl32 = 1'b0;
        chk("flush_idle_not_accepted", {busy32, r32_o}, 2'b01);

        // flush in DONE discards the pending result even with ready_i high
        rdy32_i = 1'b0;
        start32(3'b100, 32'd5, 32'd0, 32'hffffffff);
        void'(q32.pop_front());
        @(posedge clk);
        #1;
        chk("done_pending_valid", v32_o, 1);
        fl32 = 1'b1; rdy32_i = 1'b1;
        @(posedge clk);
        #1;
        fl32 = 1'b0;
        chk("flush_done_discard", {v32_o, r32_o, busy32}, 3'b010);

        // asynchronous reset in the middle of a multiply
        start32(3'b000, 32'd123, 32'd456, 32'd56088);
        void'(q32.pop_front());
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {v32_o, busy32, res32}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_mid_reset", {r32_o, busy32, v32_o}, 3'b100);
        start32(3'b000, 32'd123, 32'd456, 32'd56088);
        collect32("mul_after_reset", 33);

        // XLEN=16 random sweep against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            run16(3'($urandom_range(0, 7)), pick16(), pick16());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
